rs_trigger_checker: RTL and testbench
=====================================

# rs_trigger_checker

Synchronous checker for the clocked RS trigger: samples the trigger's R/S inputs and Q/nQ outputs, runs a reference model, and flags mismatches, complement violations and forbidden R=S=1 commands. Sits alongside the trigger in benches and in FPGA self-test builds, reading the trigger's outputs the way the stimulus generator writes its inputs. Event counters support post-run reporting.

## Interface
- LAT, 1: cycles between a command sampled on R/S and the Q/nQ sample it is checked against (1..4)
- CNT_W, 8: width of each event counter

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- R  in  1  trigger reset command, as driven to the trigger
- S  in  1  trigger set command, as driven to the trigger
- Q  in  1  trigger output
- nQ  in  1  trigger inverted output
- clr  in  1  synchronous clear of counters and sticky flags
- model_q  out  1  reference-model state
- model_valid  out  1  model state is known
- err  out  1  one-cycle error pulse
- err_code  out  2  cause of current err: 01 value mismatch, 10 complement violation, 11 both
- err_sticky  out  1  set on any err, held until clr or reset
- forbid  out  1  one-cycle pulse: R=S=1 sampled
- set_cnt, rst_cnt, forbid_cnt, err_cnt  out  CNT_W each  event counters

## Operation
- Reset: all outputs 0; model_valid=0; compare pipeline cleared (all stages invalid).
- Each edge, sample (R,S) into the model:
  - S=1,R=0: model_q←1, model_valid←1, set_cnt+1
  - R=1,S=0: model_q←0, model_valid←1, rst_cnt+1
  - R=0,S=0: hold
  - R=1,S=1: model_valid←0, forbid pulses next cycle, forbid_cnt+1
- Expected value (next model_q, next model_valid) enters a LAT-deep shift pipeline with a valid bit.
- At each edge, pipeline output stage is compared with sampled Q/nQ:
  - value mismatch: stage valid and Q ≠ expected
  - complement violation: stage valid and Q == nQ
  - either → err=1 next cycle with err_code as above, err_cnt+1, err_sticky←1
- Invalid stages (after reset or after forbidden command until the next set/reset) suppress both checks.
- Counters saturate at 2^CNT_W−1; no wrap.
- clr: counters and err_sticky to 0 on that edge; model and pipeline unaffected; an event on the same edge is discarded (clr wins).
- Simultaneous command and error on one edge: both recorded independently.

## Timing
- Command sampled at edge k is checked against Q/nQ sampled at edge k+LAT; err/err_code visible after edge k+LAT, one cycle wide.
- model_q/model_valid update after edge k; forbid pulse after edge k.
- Consecutive errors produce back-to-back err pulses, one per offending edge.
- rst_n assert mid-run: outputs clear immediately (asynchronous); first check possible LAT edges after first set/reset following release.

## Test plan
- Reset, then S=1,R=0 one cycle with Q=1,nQ=0 from LAT=1 later -> model_q=1, model_valid=1, set_cnt=1, err never asserted.
- S=1 sampled at edge k, Q held 0 at edge k+1 -> err=1, err_code=01 one cycle, err_cnt=1, err_sticky stays 1.
- Q=1,nQ=1 while model valid -> err_code=10; Q=0,nQ=0 with model_q=1 -> err_code=11.
- R=S=1 -> forbid pulse, forbid_cnt=1, model_valid=0; arbitrary Q/nQ for 5 cycles -> no err; then R=1 -> checks resume LAT edges later.
- CNT_W=2, eight set commands -> set_cnt stops at 3; clr pulse -> all counters and err_sticky 0, model_q unchanged.
- rst_n low mid-run with pending mismatch in pipeline (LAT=3) -> outputs 0 immediately, pending err never emitted.

Source files
------------

// File: rtl/rs_trigger_checker.sv
// Checker for a clocked RS trigger: reference model, delayed compare
// pipeline, error/forbid pulses and saturating event counters.
module rs_trigger_checker #(
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             R,
    input  logic             S,
    input  logic             Q,
    input  logic             nQ,
    input  logic             clr,
    output logic             model_q,
    output logic             model_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic             forbid,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] rst_cnt,
    output logic [CNT_W-1:0] forbid_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic             r_model_q;
    logic             r_model_v;
    logic             r_pipe_v [LAT];
    logic             r_pipe_q [LAT];
    logic             r_err;
    logic [1:0]       r_err_code;
    logic             r_sticky;
    logic             r_forbid;
    logic [CNT_W-1:0] r_set_cnt;
    logic [CNT_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0] r_forb_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic w_set;
    logic w_rst;
    logic w_forb;
    logic w_nxt_q;
    logic w_nxt_v;
    logic w_mism;
    logic w_cmpl;
    logic w_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_set  = S & ~R;
    assign w_rst  = R & ~S;
    assign w_forb = R & S;

    always_comb begin
        w_nxt_q = r_model_q;
        w_nxt_v = r_model_v;
        unique case (1'b1)
            w_set: begin
                w_nxt_q = 1'b1;
                w_nxt_v = 1'b1;
            end
            w_rst: begin
                w_nxt_q = 1'b0;
                w_nxt_v = 1'b1;
            end
            w_forb: w_nxt_v = 1'b0;
            default: ;
        endcase
    end

    // Oldest pipeline stage is the expectation for the Q/nQ sampled now.
    assign w_mism = r_pipe_v[LAT-1] & (Q != r_pipe_q[LAT-1]);
    assign w_cmpl = r_pipe_v[LAT-1] & (Q == nQ);
    assign w_err  = w_mism | w_cmpl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_model_q  <= 1'b0;
            r_model_v  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_forbid   <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                r_pipe_v[i] <= 1'b0;
                r_pipe_q[i] <= 1'b0;
            end
        end else begin
            r_model_q   <= w_nxt_q;
            r_model_v   <= w_nxt_v;
            r_err       <= w_err;
            r_err_code  <= {w_cmpl, w_mism};
            r_forbid    <= w_forb;
            r_pipe_v[0] <= w_nxt_v;
            r_pipe_q[0] <= w_nxt_q;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_q[i] <= r_pipe_q[i-1];
            end
        end
    end

    // clr takes priority over any event landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set_cnt  <= '0;
            r_rst_cnt  <= '0;
            r_forb_cnt <= '0;
            r_err_cnt  <= '0;
            r_sticky   <= 1'b0;
        end else if (clr) begin
            r_set_cnt  <= '0;
            r_rst_cnt  <= '0;
            r_forb_cnt <= '0;
            r_err_cnt  <= '0;
            r_sticky   <= 1'b0;
        end else begin
            if (w_set)  r_set_cnt  <= sat_inc(r_set_cnt);
            if (w_rst)  r_rst_cnt  <= sat_inc(r_rst_cnt);
            if (w_forb) r_forb_cnt <= sat_inc(r_forb_cnt);
            if (w_err) begin
                r_err_cnt <= sat_inc(r_err_cnt);
                r_sticky  <= 1'b1;
            end
        end
    end

    assign model_q     = r_model_q;
    assign model_valid = r_model_v;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign err_sticky  = r_sticky;
    assign forbid      = r_forbid;
    assign set_cnt     = r_set_cnt;
    assign rst_cnt     = r_rst_cnt;
    assign forbid_cnt  = r_forb_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_rs_trigger_checker.sv
// Bench for rs_trigger_checker: directed steps plus random traffic
// against a queue-based reference model.
module tb_rs_trigger_checker;

    localparam int LAT   = 3;
    localparam int CNT_W = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             R, S, Q, nQ, clr;
    logic             model_q, model_valid, err, err_sticky, forbid;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] set_cnt, rst_cnt, forbid_cnt, err_cnt;

    rs_trigger_checker #(.LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .R(R), .S(S), .Q(Q), .nQ(nQ),
        .clr(clr), .model_q(model_q), .model_valid(model_valid),
        .err(err), .err_code(err_code), .err_sticky(err_sticky),
        .forbid(forbid), .set_cnt(set_cnt), .rst_cnt(rst_cnt),
        .forbid_cnt(forbid_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit v;
        bit q;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   m_q, m_v, m_sticky, m_errp, m_forbp;
    bit [1:0] m_code;
    int   m_set, m_rst, m_forb, m_err;
    exp_t pipe[$];

    function automatic int inc(int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_v = 0; m_sticky = 0; m_errp = 0; m_forbp = 0;
        m_code = 0; m_set = 0; m_rst = 0; m_forb = 0; m_err = 0;
        pipe.delete();
        repeat (LAT) pipe.push_back(exp_t'(2'b00));
    endtask

    task automatic model_edge(bit r, bit s, bit q, bit nq, bit c);
        exp_t e;
        bit   mm, cv;
        e  = pipe.pop_front();
        mm = e.v && (q != e.q);
        cv = e.v && (q == nq);
        m_errp  = mm | cv;
        m_code  = {cv, mm};
        m_forbp = r & s;
        if (s && !r) begin m_q = 1; m_v = 1; m_set = inc(m_set); end
        if (r && !s) begin m_q = 0; m_v = 1; m_rst = inc(m_rst); end
        if (r && s)  begin m_v = 0; m_forb = inc(m_forb); end
        pipe.push_back(exp_t'({m_v, m_q}));
        if (m_errp) begin m_err = inc(m_err); m_sticky = 1; end
        if (c) begin
            m_set = 0; m_rst = 0; m_forb = 0; m_err = 0; m_sticky = 0;
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".model_q"}, model_q, m_q);
        chk({tag, ".model_valid"}, model_valid, m_v);
        chk({tag, ".err"}, err, m_errp);
        chk({tag, ".err_code"}, err_code, m_code);
        chk({tag, ".err_sticky"}, err_sticky, m_sticky);
        chk({tag, ".forbid"}, forbid, m_forbp);
        chk({tag, ".set_cnt"}, set_cnt, m_set);
        chk({tag, ".rst_cnt"}, rst_cnt, m_rst);
        chk({tag, ".forbid_cnt"}, forbid_cnt, m_forb);
        chk({tag, ".err_cnt"}, err_cnt, m_err);
    endtask

    task automatic step(string tag, bit r, bit s, bit q, bit nq, bit c);
        @(negedge clk);
        R = r; S = s; Q = q; nQ = nq; clr = c;
        @(posedge clk);
        model_edge(r, s, q, nq, c);
        #1 check_all(tag);
    endtask

    // Q/nQ behave like a healthy trigger: they show the value now due.
    task automatic step_good(string tag, bit r, bit s, bit c);
        bit q;
        q = pipe[0].v ? pipe[0].q : 1'($urandom_range(0, 1));
        step(tag, r, s, q, !q, c);
    endtask

    task automatic release_reset(string tag);
        @(negedge clk);
        rst_n = 1; R = 0; S = 0; Q = 0; nQ = 1; clr = 0;
        @(posedge clk);
        model_edge(0, 0, 0, 1, 0);
        #1 check_all(tag);
    endtask

    initial begin
        int sel;
        bit r, s, q, nq, c;
        rst_n = 0; R = 0; S = 0; Q = 0; nQ = 1; clr = 0;
        model_reset();
        #2 check_all("reset");
        release_reset("rel0");

        step("set", 0, 1, 0, 1, 0);
        repeat (4) step_good("hold_ok", 0, 0, 0);

        step("mism", 0, 0, 0, 1, 0);
        step("cmpl", 0, 0, 1, 1, 0);
        step("both", 0, 0, 0, 0, 0);
        step_good("after", 0, 0, 0);

        step("forbid", 1, 1, 1, 0, 0);
        repeat (2) step_good("drain", 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            q = 1'($urandom_range(0, 1));
            nq = 1'($urandom_range(0, 1));
            step("inval", 0, 0, q, nq, 0);
        end
        step("rstcmd", 1, 0, 1, 1, 0);
        repeat (2) step("wait", 0, 0, 1, 1, 0);
        step("resume", 0, 0, 1, 1, 0);

        repeat (10) step_good("sat", 0, 1, 0);
        step_good("clr", 0, 0, 1);
        step_good("postclr", 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            r = (sel >= 7);
            s = (sel >= 4 && sel <= 6) || sel == 9;
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) == 0 || !pipe[0].v) begin
                q = 1'($urandom_range(0, 1));
                nq = 1'($urandom_range(0, 1));
                step("rand", r, s, q, nq, c);
            end else begin
                step_good("rand", r, s, c);
            end
        end

        repeat (4) step_good("pre", 1, 0, 0);
        step("pend", 0, 1, 0, 1, 0);
        step("pend", 0, 0, 0, 1, 0);
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        #1 check_all("async_rst");
        repeat (2) @(posedge clk);
        #1 check_all("in_rst");
        release_reset("rel1");
        repeat (4) step("norun", 0, 0, 0, 1, 0);
        step("set2", 0, 1, 0, 1, 0);
        repeat (LAT) step("late", 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
